instr_mem_loader: RTL and testbench

//   Writer side of the instruction ROM: receives a program as a byte stream (valid/ready),

---
 rtl/instr_mem_loader_if.sv | 22 ++
 rtl/instr_mem_loader.sv | 115 +++++++++++
 tb/tb_instr_mem_loader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Boot byte stream in, instruction memory write port out.
// The loader sits on the slave side of both.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output byte_data, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_data, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Packs a length-prefixed big-endian byte stream into the
// instruction ROM, then pads the rest of the ROM with FILL_WORD.
module instr_mem_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] FILL_WORD = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  instr_mem_loader_if.slave bus,
  output logic          busy,
  output logic          done,
  output logic          error
);
  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, FILL, DONE, ERR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);
  localparam logic [15:0] LAST    = 16'(DEPTH - 1);

  state_t      state, state_n;
  logic [7:0]  hdr_hi;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] shreg;
  logic [15:0] n_hdr;
  logic        acc, hdr_ok;
  logic        last_word, short_prog;

  assign acc   = bus.byte_valid & bus.byte_ready;
  assign n_hdr = {hdr_hi, bus.byte_data};
  assign hdr_ok = (n_hdr != 16'd0) &&
                  ({1'b0, n_hdr} <= DEPTH_W);
  assign last_word = (byte_idx == 2'd3) &&
                     (word_idx == n_words - 16'd1);
  assign short_prog = {1'b0, n_words} < DEPTH_W;

  assign bus.byte_ready = state inside {HDR_HI, HDR_LO, DATA};
  assign busy  = state inside {HDR_HI, HDR_LO, DATA, FILL};
  assign done  = (state == DONE);
  assign error = (state == ERR);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE, ERR:
        if (start) state_n = HDR_HI;
      HDR_HI:
        if (acc) state_n = HDR_LO;
      HDR_LO:
        if (acc) state_n = hdr_ok ? DATA : ERR;
      DATA:
        if (acc && last_word)
          state_n = short_prog ? FILL : DONE;
      FILL:
        if (word_idx == LAST) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // word_idx doubles as the fill address once data is in
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_hi        <= '0;
      n_words       <= '0;
      word_idx      <= '0;
      byte_idx      <= '0;
      shreg         <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR:
          if (start) begin
            word_idx <= '0;
            byte_idx <= '0;
            n_words  <= '0;
          end
        HDR_HI:
          if (acc) hdr_hi <= bus.byte_data;
        HDR_LO:
          if (acc) n_words <= n_hdr;
        DATA:
          if (acc) begin
            if (byte_idx == 2'd3) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= word_idx[ADDR_W-1:0];
              bus.mem_wdata <= {shreg, bus.byte_data};
              word_idx      <= word_idx + 16'd1;
            end else begin
              shreg <= {shreg[15:0], bus.byte_data};
            end
            byte_idx <= byte_idx + 2'd1;
          end
        FILL: begin
          bus.mem_we    <= 1'b1;
          bus.mem_addr  <= word_idx[ADDR_W-1:0];
          bus.mem_wdata <= FILL_WORD;
          word_idx      <= word_idx + 16'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed + randomized checks of the instruction ROM loader
// against a whole-ROM image model built from the frame contents.
module tb_instr_mem_loader;
  localparam int          ADDR_W = 10;
  localparam int          DEPTH  = 1024;
  localparam logic [31:0] FILLW  = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, error;

  instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_mem_loader #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .FILL_WORD(FILLW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .bus(bus.slave),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int tmo = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  logic [31:0]       wq[$];

  always @(negedge clk)
    if (bus.mem_we) begin
      wa_q.push_back(bus.mem_addr);
      wd_q.push_back(bus.mem_wdata);
    end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, want);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps)
      repeat ($urandom_range(0, 2)) begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
        @(negedge clk);
      end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    t = 0;
    while (!bus.byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) tmo++;
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word_bytes(input int i, input int k0,
                                 input int k1, input bit gaps);
    logic [31:0] w;
    w = wq[i];
    for (int k = k0; k <= k1; k++)
      send(w[31-8*k -: 8], gaps);
  endtask

  task automatic send_frame(input logic [15:0] n,
                            input bit gaps);
    send(n[15:8], gaps);
    send(n[7:0], gaps);
    for (int i = 0; i < wq.size(); i++)
      send_word_bytes(i, 0, 3, gaps);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 6000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 6000) tmo++;
    repeat (2) @(negedge clk);
  endtask

  // Expected image: ROM[a] = a < n ? program word : FILL,
  // written once per address in ascending order.
  task automatic verify(input string tag, input int base,
                        input int n, input bit ok);
    int cnt, bad;
    logic [31:0] ea;
    logic [31:0] ed;
    cnt = wa_q.size() - base;
    bad = 0;
    for (int i = 0; i < cnt && i < DEPTH; i++) begin
      ea = 32'(i);
      ed = (i < n) ? wq[i] : FILLW;
      if (32'(wa_q[base+i]) !== ea || wd_q[base+i] !== ed)
        bad++;
    end
    check({tag, "_wr_count"}, 32'(cnt), ok ? 32'(DEPTH) : 32'd0);
    check({tag, "_wr_seq"}, 32'(bad), 32'd0);
    check({tag, "_done"}, 32'(done), 32'(ok));
    check({tag, "_error"}, 32'(error), 32'(!ok));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_timeouts"}, 32'(tmo), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  initial begin
    int base, sz;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;
    @(negedge clk);

    // 1: two-word program, back-to-back bytes
    wq.delete();
    wq.push_back(32'h2042_0005);
    wq.push_back(32'h2063_0007);
    base = wa_q.size();
    pulse_start();
    check("t1_busy_after_start", 32'(busy), 32'd1);
    check("t1_ready", 32'(bus.byte_ready), 32'd1);
    send_frame(16'd2, 1'b0);
    wait_idle();
    verify("t1", base, 2, 1'b1);

    // 2: same frame with random valid gaps
    base = wa_q.size();
    pulse_start();
    check("t2_done_cleared", 32'(done), 32'd0);
    send_frame(16'd2, 1'b1);
    wait_idle();
    verify("t2", base, 2, 1'b1);

    // 3: illegal word counts
    wq.delete();
    base = wa_q.size();
    pulse_start();
    send_frame(16'd0, 1'b0);
    wait_idle();
    verify("t3_zero", base, 0, 1'b0);
    check("t3_ready_in_err", 32'(bus.byte_ready), 32'd0);
    base = wa_q.size();
    pulse_start();
    check("t3_err_cleared", 32'(error), 32'd0);
    send_frame(16'd1025, 1'b0);
    wait_idle();
    verify("t3_1025", base, 0, 1'b0);

    // 4: full-depth program, no fill phase
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
    base = wa_q.size();
    pulse_start();
    send_frame(16'(DEPTH), 1'b0);
    wait_idle();
    verify("t4", base, DEPTH, 1'b1);
    check("t4_last_addr", 32'(wa_q[wa_q.size()-1]),
          32'(DEPTH - 1));

    // 5: reset after five data bytes
    wq.delete();
    wq.push_back($urandom);
    wq.push_back($urandom);
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    send_word_bytes(0, 0, 3, 1'b0);
    send_word_bytes(1, 0, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_zero("t5_rst");
    sz = wa_q.size();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_no_wr_after_rst", 32'(wa_q.size() - sz), 32'd0);
    base = wa_q.size();
    pulse_start();
    send_frame(16'd2, 1'b1);
    wait_idle();
    verify("t5", base, 2, 1'b1);

    // 6: start mid-DATA ignored; start in DONE clears done
    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back($urandom);
    base = wa_q.size();
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h03, 1'b0);
    send_word_bytes(0, 0, 3, 1'b0);
    send_word_bytes(1, 0, 1, 1'b0);
    pulse_start();
    check("t6_busy_mid", 32'(busy), 32'd1);
    send_word_bytes(1, 2, 3, 1'b0);
    send_word_bytes(2, 0, 3, 1'b0);
    wait_idle();
    verify("t6", base, 3, 1'b1);
    pulse_start();
    check("t6_done_clr", 32'(done), 32'd0);
    check("t6_busy_restart", 32'(busy), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
